// File: rtl/prince_nf_round_ctrl_pkg.sv
// Shared encodings for the PRINCE NullFresh round controller: FSM states,
// linear-layer selects, pass constants and the registered output bundle.
package prince_nf_round_ctrl_pkg;

    localparam int NUM_PASSES     = 12;
    localparam int MID_PASS       = 5;
    localparam int INV_FIRST_PASS = 6;

    localparam logic [3:0] LAST_PASS = 4'(NUM_PASSES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SBOX = 3'd2,
        ST_LIN  = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    localparam logic [1:0] LIN_FWD  = 2'd0;
    localparam logic [1:0] LIN_MID  = 2'd1;
    localparam logic [1:0] LIN_INV  = 2'd2;
    localparam logic [1:0] LIN_POST = 2'd3;

    typedef struct packed {
        logic       busy;
        logic       load_en;
        logic       sbox_en;
        logic       state_en;
        logic       inv_sel;
        logic [1:0] lin_sel;
        logic [3:0] rc_idx;
        logic       out_valid;
    } ctrl_out_t;

    // Forward M for the first half, M' in the middle, M^-1 after it, and only
    // post-whitening after the last inverse S-layer.
    function automatic logic [1:0] lin_sel_for(input logic [3:0] pass);
        if (pass == LAST_PASS) return LIN_POST;
        if (pass == 4'(MID_PASS)) return LIN_MID;
        if (pass > 4'(MID_PASS)) return LIN_INV;
        return LIN_FWD;
    endfunction

endpackage

// File: rtl/prince_nf_stage_cnt.sv
// Counts the register layers of one masked S-box pass; flags the last one.
// Holds at the last stage until cleared, so it never wraps on its own.
module prince_nf_stage_cnt #(
    parameter int SBOX_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [2:0] LAST_STAGE = 3'(SBOX_STAGES - 1);

    logic [2:0] stage_d;
    logic [2:0] stage_q;

    assign last = (stage_q == LAST_STAGE);

    always_comb begin
        stage_d = stage_q;
        if (clr) begin
            stage_d = '0;
        end else if (en && !last) begin
            stage_d = stage_q + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/prince_nf_round_ctrl.sv
// Round sequencer for the 3-share NullFresh PRINCE core: load, 12 S-layer
// passes with linear-layer/constant selects, then a valid/ready result hold.
module prince_nf_round_ctrl
    import prince_nf_round_ctrl_pkg::*;
#(
    parameter int SBOX_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out_ready,
    output logic       busy,
    output logic       load_en,
    output logic       sbox_en,
    output logic       state_en,
    output logic       inv_sel,
    output logic [1:0] lin_sel,
    output logic [3:0] rc_idx,
    output logic       out_valid
);

    state_e    state_d, state_q;
    logic [3:0] pass_d, pass_q;
    ctrl_out_t out_d, out_q;

    logic stage_clr;
    logic stage_en;
    logic stage_last;

    prince_nf_stage_cnt #(
        .SBOX_STAGES(SBOX_STAGES)
    ) u_stage_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stage_clr),
        .en  (stage_en),
        .last(stage_last)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        stage_clr = 1'b0;
        stage_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pass_d    = '0;
                stage_clr = 1'b1;
                state_d   = ST_SBOX;
            end
            ST_SBOX: begin
                stage_en = 1'b1;
                if (stage_last) begin
                    stage_clr = 1'b1;
                    state_d   = ST_LIN;
                end
            end
            ST_LIN: begin
                if (pass_q == LAST_PASS) begin
                    state_d = ST_OUT;
                end else begin
                    pass_d  = pass_q + 4'd1;
                    state_d = ST_SBOX;
                end
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each output
    // flop lines up with the state register in the same cycle.
    always_comb begin
        out_d           = '0;
        out_d.busy      = (state_d != ST_IDLE);
        out_d.load_en   = (state_d == ST_LOAD);
        out_d.sbox_en   = (state_d == ST_SBOX);
        out_d.inv_sel   = (state_d == ST_SBOX) && (pass_d >= 4'(INV_FIRST_PASS));
        out_d.state_en  = (state_d == ST_LIN);
        out_d.out_valid = (state_d == ST_OUT);
        if (state_d == ST_LIN) begin
            out_d.lin_sel = lin_sel_for(pass_d);
            out_d.rc_idx  = pass_d + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            out_q   <= out_d;
        end
    end

    assign busy      = out_q.busy;
    assign load_en   = out_q.load_en;
    assign sbox_en   = out_q.sbox_en;
    assign state_en  = out_q.state_en;
    assign inv_sel   = out_q.inv_sel;
    assign lin_sel   = out_q.lin_sel;
    assign rc_idx    = out_q.rc_idx;
    assign out_valid = out_q.out_valid;

endmodule

// File: tb/tb_prince_nf_round_ctrl.sv
// Scoreboard bench for prince_nf_round_ctrl: a default-depth and a 4-stage
// instance, per-cycle expected output vectors built from the pass schedule.
module tb_prince_nf_round_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_r [2];
    logic ready_r [2];

    logic       busy_w [2];
    logic       load_w [2];
    logic       sbox_w [2];
    logic       st_w   [2];
    logic       inv_w  [2];
    logic [1:0] lin_w  [2];
    logic [3:0] rc_w   [2];
    logic       ov_w   [2];

    // {busy, load_en, sbox_en, state_en, inv_sel, lin_sel[1:0], rc_idx[3:0], out_valid}
    logic [11:0] obs [2];
    assign obs[0] = {busy_w[0], load_w[0], sbox_w[0], st_w[0], inv_w[0], lin_w[0], rc_w[0], ov_w[0]};
    assign obs[1] = {busy_w[1], load_w[1], sbox_w[1], st_w[1], inv_w[1], lin_w[1], rc_w[1], ov_w[1]};

    always #5 clk = ~clk;

    prince_nf_round_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .out_ready(ready_r[0]),
        .busy(busy_w[0]), .load_en(load_w[0]), .sbox_en(sbox_w[0]), .state_en(st_w[0]),
        .inv_sel(inv_w[0]), .lin_sel(lin_w[0]), .rc_idx(rc_w[0]), .out_valid(ov_w[0])
    );

    prince_nf_round_ctrl #(.SBOX_STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_r[1]), .out_ready(ready_r[1]),
        .busy(busy_w[1]), .load_en(load_w[1]), .sbox_en(sbox_w[1]), .state_en(st_w[1]),
        .inv_sel(inv_w[1]), .lin_sel(lin_w[1]), .rc_idx(rc_w[1]), .out_valid(ov_w[1])
    );

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    logic [11:0] exp0 [$];
    logic [11:0] exp1 [$];

    int         cnt_load  [2];
    int         cnt_sbox  [2];
    int         cnt_state [2];
    logic [1:0] lin_log [$];
    logic [3:0] rc_log  [$];
    logic       inv_log [$];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int stages_of(input int idx);
        return (idx == 0) ? 2 : 4;
    endfunction

    function automatic logic [11:0] vec(input bit b, input bit ld, input bit sb, input bit se,
                                        input bit inv, input int lin, input int rc, input bit ov);
        logic [1:0] l;
        logic [3:0] r;
        l = 2'(lin);
        r = 4'(rc);
        return {b, ld, sb, se, inv, l, r, ov};
    endfunction

    // Reference schedule: linear layer M for passes 0..4, M' at 5, M^-1 at 6..10,
    // post-whitening only after pass 11.
    function automatic int lin_of_pass(input int p);
        if (p < 5)  return 0;
        if (p == 5) return 1;
        if (p < 11) return 2;
        return 3;
    endfunction

    task automatic push_exp(input int idx, input logic [11:0] v);
        if (idx == 0) exp0.push_back(v);
        else          exp1.push_back(v);
    endtask

    // One encryption: LOAD, then per pass S cycles of S-box and one LIN cycle,
    // then OUT held for k backpressure cycles plus the accepting cycle.
    task automatic push_txn(input int idx, input int k);
        int s;
        s = stages_of(idx);
        push_exp(idx, vec(1, 1, 0, 0, 0, 0, 0, 0));
        for (int p = 0; p < 12; p++) begin
            for (int j = 0; j < s; j++) push_exp(idx, vec(1, 0, 1, 0, p >= 6, 0, 0, 0));
            push_exp(idx, vec(1, 0, 0, 1, 0, lin_of_pass(p), p + 1, 0));
        end
        for (int j = 0; j <= k; j++) push_exp(idx, vec(1, 0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic mon_one(input int idx);
        logic [11:0] v;
        logic [11:0] e;
        bit          empty;
        v = obs[idx];
        empty = (idx == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
        if (v[11]) begin
            if (empty) begin
                check($sformatf("dut%0d_busy_without_txn", idx), v, 0);
            end else begin
                if (idx == 0) e = exp0.pop_front();
                else          e = exp1.pop_front();
                check($sformatf("dut%0d_cycle_vec", idx), v, e);
            end
        end else begin
            check($sformatf("dut%0d_idle_outputs", idx), v, 0);
        end
        if (v[10]) cnt_load[idx]++;
        if (v[9])  cnt_sbox[idx]++;
        if (v[8])  cnt_state[idx]++;
        if (idx == 0 && v[8]) begin
            lin_log.push_back(v[6:5]);
            rc_log.push_back(v[4:1]);
        end
        if (idx == 0 && v[9]) inv_log.push_back(v[7]);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 2; i++) mon_one(i);
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            cnt_load[i]  = 0;
            cnt_sbox[i]  = 0;
            cnt_state[i] = 0;
        end
        lin_log.delete();
        rc_log.delete();
        inv_log.delete();
    endtask

    // Start one encryption, check its latency, apply k cycles of backpressure
    // (optionally with ignored start pulses) and accept the result.
    task automatic run_txn(input int idx, input int k, input bit noise);
        int n;
        int ov_cycles;
        int s;
        s = stages_of(idx);
        push_txn(idx, k);
        ready_r[idx] = (k == 0);
        start_r[idx] = 1'b1;
        step();
        start_r[idx] = 1'b0;
        n = 1;
        while (!obs[idx][0] && n < 300) begin
            step();
            n++;
        end
        check($sformatf("dut%0d_latency", idx), n, 1 + 12 * (s + 1) + 1);
        ov_cycles = obs[idx][0] ? 1 : 0;
        for (int i = 0; i < k; i++) begin
            start_r[idx] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            ready_r[idx] = 1'b0;
            step();
            if (obs[idx][0]) ov_cycles++;
            check($sformatf("dut%0d_busy_during_out", idx), obs[idx][11], 1);
        end
        start_r[idx] = 1'b0;
        ready_r[idx] = 1'b1;
        step();
        check($sformatf("dut%0d_out_valid_cycles", idx), ov_cycles, k + 1);
        check($sformatf("dut%0d_back_to_idle", idx), obs[idx][11], 0);
        ready_r[idx] = 1'b0;
    endtask

    initial begin
        logic [1:0] lin_ref [12];
        int n;

        lin_ref = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0;
            ready_r[i] = 1'b0;
        end
        clear_stats();
        step();
        step();
        mon_on = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Reset in the first S-box cycle of pass 3, then a full run afterwards.
        push_txn(0, 0);
        start_r[0] = 1'b1;
        step();
        start_r[0] = 1'b0;
        repeat (10) step();
        check("pre_reset_sbox_active", obs[0][9], 1);
        rst = 1'b1;
        step();
        exp0.delete();
        check("reset_clears_outputs", obs[0], 0);
        rst = 1'b0;
        step();
        check("reset_stays_idle", obs[0], 0);

        // Default run with out_ready held high.
        clear_stats();
        run_txn(0, 0, 1'b0);
        check("load_en_cycles", cnt_load[0], 1);
        check("sbox_en_cycles", cnt_sbox[0], 24);
        check("state_en_cycles", cnt_state[0], 12);
        check("lin_log_len", lin_log.size(), 12);
        for (int i = 0; i < 12 && i < lin_log.size(); i++) begin
            check($sformatf("lin_sel_pass%0d", i), lin_log[i], lin_ref[i]);
            check($sformatf("rc_idx_pass%0d", i), rc_log[i], i + 1);
        end
        check("inv_log_len", inv_log.size(), 24);
        for (int i = 0; i < 24 && i < inv_log.size(); i++) begin
            check($sformatf("inv_sel_sbox%0d", i), inv_log[i], (i / 2) >= 6);
        end

        // Backpressure with start pulses during OUT.
        run_txn(0, 5, 1'b1);
        repeat (2) step();

        // Back-to-back: start held high across OUT -> IDLE.
        push_txn(0, 0);
        push_txn(0, 0);
        ready_r[0] = 1'b1;
        start_r[0] = 1'b1;
        n = 0;
        while (!obs[0][0] && n < 300) begin
            step();
            n++;
        end
        check("b2b_first_latency", n, 38);
        step();
        check("b2b_idle_gap", obs[0][11], 0);
        step();
        check("b2b_second_load", obs[0][10], 1);
        start_r[0] = 1'b0;
        n = 0;
        while (!obs[0][0] && n < 300) begin
            step();
            n++;
        end
        check("b2b_second_latency", n, 37);
        step();
        check("b2b_back_to_idle", obs[0][11], 0);
        ready_r[0] = 1'b0;

        // Four-stage S-box instance.
        clear_stats();
        run_txn(1, 0, 1'b0);
        check("dut1_load_en_cycles", cnt_load[1], 1);
        check("dut1_sbox_en_cycles", cnt_sbox[1], 48);
        check("dut1_state_en_cycles", cnt_state[1], 12);

        // Randomized traffic on both instances.
        for (int t = 0; t < 6; t++) begin
            int idx;
            int k;
            idx = int'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 4));
            repeat ($urandom_range(0, 3)) step();
            run_txn(idx, k, 1'b1);
        end

        repeat (2) step();
        check("dut0_queue_drained", exp0.size(), 0);
        check("dut1_queue_drained", exp1.size(), 0);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
